// File: rtl/pls_cont_pkg.sv
// Shared types for the multi-axis step/direction pulse controller.
// Array typedefs describe the default three-axis, 32-bit configuration.
package pls_cont_pkg;

    localparam int AXES_DEF = 3;
    localparam int N_W_DEF  = 32;
    localparam int P_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic signed [N_W_DEF-1:0] n_arr_t   [AXES_DEF];
    typedef logic        [N_W_DEF-1:0] abs_arr_t [AXES_DEF];
    typedef logic signed [P_W_DEF-1:0] pos_arr_t [AXES_DEF];

endpackage

// File: rtl/pls_dda_axis.sv
// One axis of the DDA: Bresenham accumulator, fixed-width step pulse
// stretcher and signed position counter.
module pls_dda_axis #(
    parameter int N_W   = 32,
    parameter int P_W   = 32,
    parameter int PLS_W = 8
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  neg,
    input  logic [N_W-1:0]        abs_in,
    input  logic [N_W-1:0]        acc_init,
    input  logic [N_W-1:0]        major,
    input  logic                  step,
    output logic                  pls,
    output logic                  dir,
    output logic signed [P_W-1:0] pos
);

    localparam int CW = $clog2(PLS_W + 1);

    logic [N_W-1:0] abs_q;
    logic [N_W-1:0] acc;
    logic [N_W:0]   sum;
    logic [CW-1:0]  cnt;
    logic           fire;

    // acc < major and abs <= major, so the sum always fits in N_W+1 bits
    assign sum  = {1'b0, acc} + {1'b0, abs_q};
    assign fire = step && (sum >= {1'b0, major});

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            abs_q <= '0;
            acc   <= '0;
            cnt   <= '0;
            pls   <= 1'b0;
            dir   <= 1'b0;
            pos   <= '0;
        end else begin
            if (load) begin
                abs_q <= abs_in;
                acc   <= acc_init;
                dir   <= neg;
            end else if (step) begin
                acc <= fire ? sum[N_W-1:0] - major : sum[N_W-1:0];
            end

            if (clr) begin
                pls <= 1'b0;
                cnt <= '0;
            end else if (fire) begin
                pls <= 1'b1;
                cnt <= CW'(PLS_W - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                pls <= 1'b0;
            end

            if (fire) begin
                pos <= dir ? pos - P_W'(1) : pos + P_W'(1);
            end
        end
    end

endmodule

// File: rtl/pls_cont_multi.sv
// Multi-axis step/direction controller: pops segments from a show-ahead FIFO
// and distributes steps over the axes against the major axis.
//
// state | meaning
// IDLE  | waiting for a segment; pops on !empty
// SETUP | dir settling for DIR_SETUP clocks, then waits for permit
// STEP  | one step start per Teff clocks until major steps are done
// DONE  | segment complete, oi_req held until oi
module pls_cont_multi
    import pls_cont_pkg::*;
#(
    parameter int AXES      = 3,
    parameter int N_W       = 32,
    parameter int T_W       = 32,
    parameter int P_W       = 32,
    parameter int PLS_W     = 8,
    parameter int DIR_SETUP = 16
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  abort,
    input  logic                  empty,
    input  logic [AXES*N_W-1:0]   N,
    input  logic [T_W-1:0]        T,
    output logic                  rdack,
    input  logic                  permit,
    input  logic                  oi,
    output logic                  oi_req,
    output logic                  run,
    output logic [AXES-1:0]       pls,
    output logic [AXES-1:0]       dir,
    output logic [AXES*P_W-1:0]   pos
);

    localparam logic [T_W-1:0] T_MIN = T_W'(2 * PLS_W);

    state_t         state, state_nxt;
    logic [T_W-1:0] tmr;
    logic [T_W-1:0] teff;
    logic [N_W-1:0] major;
    logic [N_W-1:0] rem;
    logic [N_W-1:0] major_in;
    logic [N_W-1:0] abs_in [AXES];
    logic           step_go;
    logic           per_load;

    // Two's-complement magnitude; the most negative value maps to 2^(N_W-1)
    always_comb begin
        major_in = '0;
        for (int i = 0; i < AXES; i++) begin
            abs_in[i] = N[i*N_W + N_W - 1] ? (~N[i*N_W +: N_W]) + N_W'(1)
                                           : N[i*N_W +: N_W];
            if (abs_in[i] > major_in) begin
                major_in = abs_in[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rdack     = 1'b0;
        step_go   = 1'b0;
        per_load  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        rdack     = 1'b1;
                        state_nxt = SETUP;
                    end
                end
                SETUP: begin
                    // A pause still loads one period, just without a step
                    if (tmr == '0 && permit) begin
                        state_nxt = STEP;
                        per_load  = 1'b1;
                        step_go   = (rem != '0);
                    end
                end
                STEP: begin
                    if (tmr == '0) begin
                        if (rem == '0) begin
                            state_nxt = DONE;
                        end else if (permit) begin
                            per_load = 1'b1;
                            step_go  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (oi) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= IDLE;
            tmr   <= '0;
            teff  <= '0;
            major <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            if (rdack) begin
                tmr   <= T_W'(DIR_SETUP);
                teff  <= (T > T_MIN) ? T : T_MIN;
                major <= major_in;
                rem   <= major_in;
            end else if (per_load) begin
                tmr <= teff - T_W'(1);
                if (step_go) begin
                    rem <= rem - N_W'(1);
                end
            end else if (tmr != '0) begin
                tmr <= tmr - T_W'(1);
            end
        end
    end

    assign run    = (state != IDLE);
    assign oi_req = (state == DONE);

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        pls_dda_axis #(
            .N_W   (N_W),
            .P_W   (P_W),
            .PLS_W (PLS_W)
        ) u_axis (
            .clk      (clk),
            .aclr_n   (aclr_n),
            .clr      (abort),
            .load     (rdack),
            .neg      (N[i*N_W + N_W - 1]),
            .abs_in   (abs_in[i]),
            .acc_init (major_in >> 1),
            .major    (major),
            .step     (step_go),
            .pls      (pls[i]),
            .dir      (dir[i]),
            .pos      (pos[i*P_W +: P_W])
        );
    end

endmodule

// File: tb/tb_pls_cont_multi.sv
// Directed bench for pls_cont_multi: queued segments, pulse timing, permit
// hold, abort, back-to-back handshake and asynchronous reset.
module tb_pls_cont_multi;

    localparam int AXES      = 3;
    localparam int N_W       = 32;
    localparam int T_W       = 32;
    localparam int P_W       = 32;
    localparam int PLS_W     = 8;
    localparam int DIR_SETUP = 16;

    logic                clk = 1'b0;
    logic                aclr_n = 1'b0;
    logic                abort = 1'b0;
    logic                empty;
    logic [AXES*N_W-1:0] N;
    logic [T_W-1:0]      T;
    logic                rdack;
    logic                permit = 1'b0;
    logic                oi = 1'b0;
    logic                oi_req;
    logic                run;
    logic [AXES-1:0]     pls;
    logic [AXES-1:0]     dir;
    logic [AXES*P_W-1:0] pos;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nrd = 0;
    int rd_t = 0;
    int wbad = 0;
    int rq0[$];
    int rq1[$];
    int rq2[$];
    int hi[AXES] = '{default: 0};
    logic [AXES-1:0] pls_q = '0;
    logic [AXES*N_W-1:0] qn[$];
    logic [T_W-1:0]      qt[$];
    longint ep[AXES] = '{default: 0};

    always #5 clk = ~clk;

    pls_cont_multi #(
        .AXES      (AXES),
        .N_W       (N_W),
        .T_W       (T_W),
        .P_W       (P_W),
        .PLS_W     (PLS_W),
        .DIR_SETUP (DIR_SETUP)
    ) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .abort  (abort),
        .empty  (empty),
        .N      (N),
        .T      (T),
        .rdack  (rdack),
        .permit (permit),
        .oi     (oi),
        .oi_req (oi_req),
        .run    (run),
        .pls    (pls),
        .dir    (dir),
        .pos    (pos)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Show-ahead FIFO model: pop decided mid-cycle, head updated after the edge
    initial begin
        logic pop;
        empty = 1'b1;
        N = '0;
        T = '0;
        forever begin
            @(negedge clk);
            pop = rdack;
            if (pop) begin
                nrd++;
                rd_t = cyc;
            end
            @(posedge clk);
            #2;
            if (pop && qn.size() > 0) begin
                void'(qn.pop_front());
                void'(qt.pop_front());
            end
            if (qn.size() > 0) begin
                empty = 1'b0;
                N = qn[0];
                T = qt[0];
            end else begin
                empty = 1'b1;
            end
        end
    end

    // Rise times per axis and count of pulses whose high time is not PLS_W
    always @(negedge clk) begin
        for (int i = 0; i < AXES; i++) begin
            if (pls[i] && !pls_q[i]) begin
                if (i == 0) rq0.push_back(cyc);
                else if (i == 1) rq1.push_back(cyc);
                else rq2.push_back(cyc);
            end
            if (pls[i]) begin
                hi[i]++;
            end else if (pls_q[i]) begin
                if (hi[i] != PLS_W) wbad++;
                hi[i] = 0;
            end
        end
        pls_q = pls;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint posv(input int i);
        return longint'($signed(pos[i*P_W +: P_W]));
    endfunction

    task automatic push(input int n0, input int n1, input int n2, input int t);
        qn.push_back({N_W'(n2), N_W'(n1), N_W'(n0)});
        qt.push_back(T_W'(t));
    endtask

    task automatic wait_oi(input string tag, input int budget, output int t);
        int k;
        k = 0;
        while (!oi_req && k < budget) begin
            tick();
            k++;
        end
        t = cyc;
        chk(tag, oi_req, 1);
    endtask

    task automatic wait_rise0(input string tag, input int base, input int budget);
        int k;
        k = 0;
        while (rq0.size() == base && k < budget) begin
            tick();
            k++;
        end
        chk(tag, rq0.size() - base, 1);
    endtask

    task automatic ack();
        oi = 1'b1;
        tick();
        oi = 1'b0;
    endtask

    task automatic chk_pos(input string tag);
        for (int i = 0; i < AXES; i++) begin
            chk(tag, posv(i), ep[i]);
        end
    endtask

    initial begin
        int s, d, d1, f, k, b0, b1, b2, r;

        repeat (3) tick();
        chk("rst_run", run, 0);
        chk("rst_oi_req", oi_req, 0);
        chk("rst_pls", pls, 0);
        chk("rst_dir", dir, 0);
        chk("rst_pos", pos, 0);
        aclr_n = 1'b1;
        repeat (2) tick();
        chk("idle_rdack", rdack, 0);

        // Delayed permit, negative direction
        b0 = rq0.size();
        push(-2, 0, 0, 300);
        k = 0;
        while (!run && k < 50) begin
            tick();
            k++;
        end
        s = cyc;
        chk("t1_run", run, 1);
        chk("t1_rd_t", rd_t, s - 1);
        chk("t1_dir", dir, 3'b001);
        repeat (20) tick();
        permit = 1'b1;
        wait_oi("t1_done", 1000, d);
        chk("t1_npls", rq0.size() - b0, 2);
        chk("t1_first", rq0[b0], s + 21);
        chk("t1_gap", rq0[b0+1] - rq0[b0], 300);
        chk("t1_dur", d - rq0[b0], 600);
        ep[0] -= 2;
        chk_pos("t1_pos");
        repeat (5) tick();
        chk("t1_hold", oi_req, 1);
        ack();
        chk("t1_ack", oi_req, 0);
        chk("t1_idle", run, 0);

        // Mixed ratios: minor axis steps once, at the second step
        b0 = rq0.size(); b1 = rq1.size(); b2 = rq2.size();
        push(3, 1, -3, 200);
        wait_oi("t2_done", 2000, d);
        chk("t2_n0", rq0.size() - b0, 3);
        chk("t2_n1", rq1.size() - b1, 1);
        chk("t2_n2", rq2.size() - b2, 3);
        chk("t2_ax1_at_step2", rq1[b1], rq0[b0+1]);
        chk("t2_ax2_sync", rq2[b2], rq0[b0]);
        chk("t2_first", rq0[b0], rd_t + DIR_SETUP + 2);
        chk("t2_gap", rq0[b0+2] - rq0[b0+1], 200);
        chk("t2_dur", d - rq0[b0], 600);
        chk("t2_dir", dir, 3'b100);
        ep[0] += 3; ep[1] += 1; ep[2] -= 3;
        chk_pos("t2_pos");
        ack();

        // Pause segment
        b0 = rq0.size(); b1 = rq1.size(); b2 = rq2.size();
        push(0, 0, 0, 500);
        wait_oi("t3_done", 1000, d);
        chk("t3_npls", (rq0.size() - b0) + (rq1.size() - b1) + (rq2.size() - b2), 0);
        chk("t3_dur", d - rd_t, DIR_SETUP + 2 + 500);
        chk_pos("t3_pos");
        ack();

        // Short period clamped to 2*PLS_W
        b0 = rq0.size();
        push(2, 0, 0, 3);
        wait_oi("t4_done", 200, d);
        chk("t4_first", rq0[b0], rd_t + DIR_SETUP + 2);
        chk("t4_gap", rq0[b0+1] - rq0[b0], 16);
        chk("t4_dur", d - rq0[b0], 32);
        ep[0] += 2;
        chk_pos("t4_pos");
        ack();

        // Permit dropped while the first pulse is still high
        b0 = rq0.size();
        push(3, 0, 0, 100);
        wait_rise0("t5_rise", b0, 100);
        f = rq0[b0];
        repeat (2) tick();
        permit = 1'b0;
        repeat (150) tick();
        chk("t5_held", rq0.size() - b0, 1);
        permit = 1'b1;
        wait_oi("t5_done", 1000, d);
        chk("t5_resume", rq0[b0+1], f + 154);
        chk("t5_gap", rq0[b0+2] - rq0[b0+1], 100);
        chk("t5_dur", d, f + 354);
        ep[0] += 3;
        chk_pos("t5_pos");
        ack();

        // Abort mid-pulse on the third step
        b0 = rq0.size();
        push(10, 0, 0, 100);
        wait_rise0("t6_rise", b0, 100);
        repeat (201) tick();
        chk("t6_pls_hi", pls[0], 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_pls_clr", pls, 0);
        chk("t6_run", run, 0);
        chk("t6_oi_req", oi_req, 0);
        ep[0] += 3;
        chk_pos("t6_pos");
        repeat (150) tick();
        chk("t6_npls", rq0.size() - b0, 3);
        chk_pos("t6_pos_frozen");

        // Back-to-back segments with a direction reversal
        r = nrd;
        push(2, 0, 0, 50);
        push(-1, 0, 0, 50);
        wait_oi("t7_done1", 500, d1);
        chk("t7_dir_fwd", dir, 3'b000);
        chk("t7_one_pop", nrd - r, 1);
        ack();
        tick();
        chk("t7_rdack_after_oi", rd_t, d1 + 1);
        chk("t7_dir_flip", dir, 3'b001);
        wait_oi("t7_done2", 500, d);
        ep[0] += 1;
        chk_pos("t7_pos");
        chk("t7_two_pops", nrd - r, 2);
        ack();

        // Asynchronous reset between pulses of a running segment
        b0 = rq0.size();
        push(4, 0, 0, 100);
        wait_rise0("t8_rise", b0, 100);
        repeat (50) tick();
        chk("t8_running", run, 1);
        aclr_n = 1'b0;
        #1;
        chk("t8_run", run, 0);
        chk("t8_pos", pos, 0);
        chk("t8_pls", pls, 0);
        chk("t8_oi_req", oi_req, 0);
        tick();
        aclr_n = 1'b1;
        repeat (3) tick();
        chk("t8_idle", run, 0);

        chk("pls_width_bad", wbad, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
